// File: rtl/if_stage_if.sv
// if_stage_if: groups the fetch stage's control, memory and IF/ID signals.
//   stall, flush, pcSrc, branchTarget : hazard/control inputs to the stage
//   instruction                       : word read combinationally from instruction memory
//   instructionAddress                : word address to instruction memory (pc[11:2])
//   pc                                : current fetch PC
//   ifid_instruction, ifid_pcPlus4,
//   ifid_valid                        : IF/ID pipeline register contents
//   fetchCount                        : count of real instructions latched into IF/ID
// Modports:
//   master : the environment side (control unit, hazard unit, instruction memory)
//   slave  : the fetch stage itself
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic [31:0] instruction;
  logic [9:0]  instructionAddress;
  logic [31:0] pc;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pcPlus4;
  logic        ifid_valid;
  logic [31:0] fetchCount;

  modport master (
    output stall, flush, pcSrc, branchTarget, instruction,
    input  instructionAddress, pc, ifid_instruction, ifid_pcPlus4, ifid_valid, fetchCount
  );

  modport slave (
    input  stall, flush, pcSrc, branchTarget, instruction,
    output instructionAddress, pc, ifid_instruction, ifid_pcPlus4, ifid_valid, fetchCount
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register and IF/ID pipeline register.
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_reset : synchronous active-high reset
//   bus     : if_stage_if.slave (control inputs, memory word in, IF/ID and PC out)
// Parameters:
//   RESET_PC : PC loaded on reset
//   NOP_WORD : bubble instruction placed in IF/ID on reset and flush
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  if_stage_if.slave   bus
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instruction;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_ifid_instruction_next;
  logic [31:0] w_ifid_pc_plus4_next;
  logic        w_ifid_valid_next;
  logic [31:0] w_fetch_count_next;
  logic        w_load;

  // Redirect targets are word aligned; the low two target bits are dropped.
  logic w_unused_target_bits;
  assign w_unused_target_bits = ^bus.branchTarget[1:0];

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_next               = r_pc;
    w_ifid_instruction_next = r_ifid_instruction;
    w_ifid_pc_plus4_next    = r_ifid_pc_plus4;
    w_ifid_valid_next       = r_ifid_valid;
    w_load                  = 1'b0;

    // A redirect wins over a stall so a taken branch is never lost.
    if (bus.pcSrc) begin
      w_pc_next = {bus.branchTarget[31:2], 2'b00};
    end else if (!bus.stall) begin
      w_pc_next = w_pc_plus4;
    end

    // Flush wins over stall: the squashed slot must become a bubble.
    if (bus.flush) begin
      w_ifid_instruction_next = NOP_WORD;
      w_ifid_pc_plus4_next    = 32'd0;
      w_ifid_valid_next       = 1'b0;
    end else if (!bus.stall) begin
      w_ifid_instruction_next = bus.instruction;
      w_ifid_pc_plus4_next    = w_pc_plus4;
      w_ifid_valid_next       = 1'b1;
      w_load                  = 1'b1;
    end

    w_fetch_count_next = w_load ? r_fetch_count + 32'd1 : r_fetch_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc               <= RESET_PC;
      r_ifid_instruction <= NOP_WORD;
      r_ifid_pc_plus4    <= 32'd0;
      r_ifid_valid       <= 1'b0;
      r_fetch_count      <= 32'd0;
    end else begin
      r_pc               <= w_pc_next;
      r_ifid_instruction <= w_ifid_instruction_next;
      r_ifid_pc_plus4    <= w_ifid_pc_plus4_next;
      r_ifid_valid       <= w_ifid_valid_next;
      r_fetch_count      <= w_fetch_count_next;
    end
  end

  // Memory holds 1024 words, so the word address wraps with pc[11:2].
  assign bus.instructionAddress = r_pc[11:2];
  assign bus.pc                 = r_pc;
  assign bus.ifid_instruction   = r_ifid_instruction;
  assign bus.ifid_pcPlus4       = r_ifid_pc_plus4;
  assign bus.ifid_valid         = r_ifid_valid;
  assign bus.fetchCount         = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
// Instruction memory model: word n holds the value n.
module tb_if_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // Combinational instruction memory: word n = n.
  assign bus.instruction = {22'd0, bus.instructionAddress};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcp4;
    logic        exp_valid;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stall, input logic flush, input logic pc_src,
                     input logic [31:0] target, input logic [31:0] exp_pc,
                     input logic [31:0] exp_instr, input logic [31:0] exp_pcp4,
                     input logic exp_valid, input logic [31:0] exp_count);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.pc_src = pc_src; v.target = target;
    v.exp_pc = exp_pc; v.exp_instr = exp_instr; v.exp_pcp4 = exp_pcp4;
    v.exp_valid = exp_valid; v.exp_count = exp_count;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcp4, input logic e_valid,
                           input logic [31:0] e_count);
    logic [31:0] e_ia;
    e_ia = {22'd0, e_pc[11:2]};
    check("pc", row, bus.pc, e_pc);
    check("instructionAddress", row, {22'd0, bus.instructionAddress}, e_ia);
    check("ifid_instruction", row, bus.ifid_instruction, e_instr);
    check("ifid_pcPlus4", row, bus.ifid_pcPlus4, e_pcp4);
    check("ifid_valid", row, {31'd0, bus.ifid_valid}, {31'd0, e_valid});
    check("fetchCount", row, bus.fetchCount, e_count);
    checks++;
    if ($isunknown({bus.pc, bus.instructionAddress, bus.ifid_instruction, bus.ifid_pcPlus4,
                    bus.ifid_valid, bus.fetchCount})) begin
      failures++;
      $display("FAIL no_x row=%0d actual=unknown expected=known", row);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic pc_src, input logic [31:0] target);
    reset            = rst;
    bus.stall        = stall;
    bus.flush        = flush;
    bus.pcSrc        = pc_src;
    bus.branchTarget = target;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always reaches an end.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.pcSrc = 1'b0; bus.branchTarget = 32'd0;
    #1;

    // Reset for 10 cycles, with noisy control inputs on some of them.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], i[1], i[2], 32'h0000_0100);
      if (i == 0 || i == 9) check_all(-1 - i, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    end

    //   rst   stall flush pcSrc target        pc            instr         pcPlus4       v     count
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        1'b1, 32'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1,        32'h8,        1'b1, 32'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1,        32'h8,        1'b1, 32'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1,        32'h8,        1'b1, 32'd2);
    add(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1,        32'h8,        1'b1, 32'd2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h2,        32'hC,        1'b1, 32'd3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'h3,        32'h10,       1'b1, 32'd4);
    // Taken branch at pc=16: redirect and bubble together.
    add(1'b0, 1'b0, 1'b1, 1'b1, 32'h43,       32'h40,       32'h0,        32'h0,        1'b0, 32'd4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h10,       32'h44,       1'b1, 32'd5);
    // Stall together with redirect and flush.
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'h20,       32'h20,       32'h0,        32'h0,        1'b0, 32'd5);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'h8,        32'h24,       1'b1, 32'd6);
    // Redirect without flush still loads the current fetch into IF/ID.
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFC,      32'hFFC,      32'h9,        32'h28,       1'b1, 32'd7);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1000,     32'h3FF,      32'h1000,     1'b1, 32'd8);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1004,     32'h0,        32'h1004,     1'b1, 32'd9);
    // Flush alone bubbles IF/ID but the PC still advances.
    add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h1008,     32'h0,        32'h0,        1'b0, 32'd9);
    // Reset during stall.
    add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        1'b1, 32'd1);
    // PC wrap at the top of the 32-bit space.
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1,      32'h8,        1'b1, 32'd2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3FF,      32'h0,        1'b1, 32'd3);
    // Reset overrides redirect and flush.
    add(1'b1, 1'b0, 1'b1, 1'b1, 32'h80,       32'h0,        32'h0,        32'h0,        1'b0, 32'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        1'b1, 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].pc_src, vecs[i].target);
      check_all(i, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pcp4, vecs[i].exp_valid,
                vecs[i].exp_count);
    end

    // Long stall: everything frozen over several edges, then release.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_all(100 + i, 32'h4, 32'h0, 32'h4, 1'b1, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all(105, 32'h8, 32'h1, 32'h8, 1'b1, 32'd2);

    // Back-to-back redirects with flush: each edge bubbles, count frozen.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    check_all(106, 32'h200, 32'h0, 32'h0, 1'b0, 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h302);
    check_all(107, 32'h300, 32'h0, 32'h0, 1'b0, 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_all(108, 32'h304, 32'hC0, 32'h304, 1'b1, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
